// File: rtl/fir_pkg.sv
// Shared constants and the Q1.15 coefficient table for the 64-tap low-pass FIR
// (windowed sinc, cutoff 0.1*fs, Hamming window, scaled for unity DC gain).
package fir_pkg;

  localparam int ADDR_WIDTH = 7;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_TAPS   = 64;
  localparam int TAP_IDX_W  = $clog2(NUM_TAPS);

  typedef logic signed [DATA_WIDTH-1:0] coeff_t;

  // Generated offline; symmetric about taps 31/32, word sum 32766.
  localparam coeff_t COEFF_TABLE [NUM_TAPS] = '{
     16'sd21,    16'sd9,     -16'sd10,   -16'sd30,
    -16'sd44,   -16'sd43,    -16'sd20,    16'sd25,
     16'sd79,    16'sd117,    16'sd114,   16'sd52,
    -16'sd62,   -16'sd190,   -16'sd274,  -16'sd259,
    -16'sd115,   16'sd133,    16'sd402,   16'sd573,
     16'sd535,   16'sd237,   -16'sd274,  -16'sd839,
    -16'sd1221, -16'sd1178,  -16'sd547,   16'sd684,
     16'sd2346,  16'sd4115,   16'sd5600,  16'sd6447,
     16'sd6447,  16'sd5600,   16'sd4115,  16'sd2346,
     16'sd684,  -16'sd547,   -16'sd1178, -16'sd1221,
    -16'sd839,  -16'sd274,    16'sd237,   16'sd535,
     16'sd573,   16'sd402,    16'sd133,  -16'sd115,
    -16'sd259,  -16'sd274,   -16'sd190,  -16'sd62,
     16'sd52,    16'sd114,    16'sd117,   16'sd79,
     16'sd25,   -16'sd20,    -16'sd43,   -16'sd44,
    -16'sd30,   -16'sd10,     16'sd9,     16'sd21
  };

  // Addresses past the populated taps read as zero rather than aliasing.
  function automatic coeff_t coeff_lookup(input logic [ADDR_WIDTH-1:0] addr);
    coeff_t word;
    word = '0;
    if (int'(addr) < NUM_TAPS) word = COEFF_TABLE[addr[TAP_IDX_W-1:0]];
    return word;
  endfunction

endpackage

// File: rtl/fir_coeff_rom_if.sv
// Read port between the FIR tap sequencer (master) and the coefficient ROM (slave).
interface fir_coeff_rom_if;
  import fir_pkg::*;

  logic [ADDR_WIDTH-1:0] address;
  coeff_t                q;

  modport master (output address, input q);
  modport slave  (input address, output q);

endinterface

// File: rtl/fir_coeff_rom.sv
// Single-port coefficient ROM: address sampled on the rising edge, word
// presented from a register one cycle later; reset_n clears the word asynchronously.
module fir_coeff_rom
  import fir_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  fir_coeff_rom_if.slave bus
);

  coeff_t q_reg;

  // The lookup sits in front of the register, so q never sees address directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q_reg <= '0;
    else          q_reg <= coeff_lookup(bus.address);
  end

  assign bus.q = q_reg;

endmodule

// File: tb/tb_fir_coeff_rom.sv
// Scoreboard bench for fir_coeff_rom: expected words queued as addresses are
// driven on the falling edge, popped and compared just after the rising edge.
module tb_fir_coeff_rom;
  import fir_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  coeff_t exp_q[$];
  coeff_t rd [NUM_TAPS];
  coeff_t last_q;

  always #5 clock = ~clock;

  fir_coeff_rom_if bus();

  fir_coeff_rom dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic coeff_t model(input int a);
    if (a >= 0 && a < NUM_TAPS) return COEFF_TABLE[a[TAP_IDX_W-1:0]];
    return '0;
  endfunction

  task automatic test_reset();
    coeff_t e;
    reset_n = 1'b0;
    bus.address = 7'd5;
    repeat (4) begin
      @(posedge clock); #1;
      tests_run++;
      if (bus.q !== 16'h0000) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold: got %h expected 0000", bus.q);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    bus.address = 7'd5;
    exp_q.push_back(model(5));
    @(posedge clock); #1;
    e = exp_q.pop_front();
    tests_run++;
    if (bus.q !== e) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_read: got %0d expected %0d", bus.q, e);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.q !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL async_clear: got %h expected 0000", bus.q);
    end
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    last_q = model(5);
  endtask

  task automatic test_latency();
    coeff_t e;
    for (int n = 0; n < NUM_TAPS; n++) begin
      @(negedge clock);
      bus.address = n[ADDR_WIDTH-1:0];
      exp_q.push_back(model(n));
      #2;
      tests_run++;
      if (bus.q !== last_q) begin
        tests_failed++;
        $display("[TB] FAIL no_comb_path[%0d]: got %0d expected %0d", n, bus.q, last_q);
      end
      @(posedge clock); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (bus.q !== e) begin
        tests_failed++;
        $display("[TB] FAIL latency[%0d]: got %0d expected %0d", n, bus.q, e);
      end
      last_q = e;
    end
  endtask

  task automatic test_symmetry_gain();
    coeff_t e;
    coeff_t max_val;
    int sum;
    int max_count;
    for (int n = 0; n < NUM_TAPS; n++) begin
      @(negedge clock);
      bus.address = n[ADDR_WIDTH-1:0];
      exp_q.push_back(model(n));
      @(posedge clock); #1;
      e = exp_q.pop_front();
      rd[n[TAP_IDX_W-1:0]] = bus.q;
      tests_run++;
      if (bus.q !== e) begin
        tests_failed++;
        $display("[TB] FAIL read_all[%0d]: got %0d expected %0d", n, bus.q, e);
      end
      last_q = e;
    end
    for (int k = 0; k < NUM_TAPS / 2; k++) begin
      tests_run++;
      if (rd[k] !== rd[NUM_TAPS-1-k]) begin
        tests_failed++;
        $display("[TB] FAIL symmetry[%0d]: got %0d expected %0d", k, rd[k], rd[NUM_TAPS-1-k]);
      end
    end
    sum = 0;
    max_val = rd[0];
    for (int k = 0; k < NUM_TAPS; k++) begin
      sum += int'(rd[k]);
      if (rd[k] > max_val) max_val = rd[k];
    end
    max_count = 0;
    for (int k = 0; k < NUM_TAPS; k++) if (rd[k] == max_val) max_count++;
    tests_run++;
    if (sum < 32704 || sum > 32832) begin
      tests_failed++;
      $display("[TB] FAIL dc_gain: got sum %0d expected 32704..32832", sum);
    end
    tests_run++;
    if (rd[31] !== max_val || rd[32] !== max_val || max_count != 2) begin
      tests_failed++;
      $display("[TB] FAIL peak_position: got q31=%0d q32=%0d count=%0d expected both %0d count=2",
               rd[31], rd[32], max_count, max_val);
    end
  endtask

  task automatic test_unpopulated();
    coeff_t e;
    for (int a = NUM_TAPS; a < 2**ADDR_WIDTH; a++) begin
      @(negedge clock);
      bus.address = a[ADDR_WIDTH-1:0];
      exp_q.push_back(model(a));
      @(posedge clock); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (bus.q !== e || bus.q !== 16'h0000) begin
        tests_failed++;
        $display("[TB] FAIL unpopulated[%0d]: got %h expected 0000", a, bus.q);
      end
      last_q = e;
    end
  endtask

  task automatic test_mid_reset();
    coeff_t e;
    for (int a = 10; a <= 11; a++) begin
      @(negedge clock);
      bus.address = a[ADDR_WIDTH-1:0];
      exp_q.push_back(model(a));
      @(posedge clock); #1;
      e = exp_q.pop_front();
      tests_run++;
      if (bus.q !== e) begin
        tests_failed++;
        $display("[TB] FAIL stream[%0d]: got %0d expected %0d", a, bus.q, e);
      end
    end
    @(negedge clock);
    bus.address = 7'd12;
    exp_q.push_back(model(12));
    #1 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.q !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_clear: got %h expected 0000", bus.q);
    end
    #2 reset_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(model(12));
    @(posedge clock); #1;
    e = exp_q.pop_front();
    tests_run++;
    if (bus.q !== e) begin
      tests_failed++;
      $display("[TB] FAIL after_mid_reset: got %0d expected %0d", bus.q, e);
    end
    last_q = e;
  endtask

  task automatic test_glitch();
    coeff_t e;
    @(negedge clock);
    bus.address = 7'd20;
    #1;
    tests_run++;
    if (bus.q !== last_q) begin
      tests_failed++;
      $display("[TB] FAIL glitch_hold_a: got %0d expected %0d", bus.q, last_q);
    end
    #1 bus.address = 7'd40;
    exp_q.push_back(model(40));
    #1;
    tests_run++;
    if (bus.q !== last_q) begin
      tests_failed++;
      $display("[TB] FAIL glitch_hold_b: got %0d expected %0d", bus.q, last_q);
    end
    @(posedge clock); #1;
    e = exp_q.pop_front();
    tests_run++;
    if (bus.q !== e) begin
      tests_failed++;
      $display("[TB] FAIL glitch_result: got %0d expected %0d", bus.q, e);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.address = '0;
    last_q = '0;
    test_reset();
    test_latency();
    test_symmetry_gain();
    test_unpopulated();
    test_mid_reset();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
